// File: rtl/cal_pkg.sv
// Shared types and calendar helpers for the day-offset engine.
// REAL_MONTH_LEN_EN selects the real (non-leap) month-length table.
package cal_pkg;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    localparam logic DIR_BACK = 1'b0;
    localparam logic DIR_FWD  = 1'b1;

`ifdef REAL_MONTH_LEN_EN
    // Month 0 or out-of-range months have length 0, which makes any day invalid.
    function automatic logic [31:0] month_len(input logic [31:0] m);
        case (m)
            32'd2:                          return 32'd28;
            32'd4, 32'd6, 32'd9, 32'd11:    return 32'd30;
            32'd1, 32'd3, 32'd5, 32'd7,
            32'd8, 32'd10, 32'd12:          return 32'd31;
            default:                        return 32'd0;
        endcase
    endfunction
`endif

endpackage

// File: rtl/day_step.sv
// Combinational single-day step forward or backward with month/year rollover.
// Month lengths come from cal_pkg::month_len when REAL_MONTH_LEN_EN is defined.
module day_step
    import cal_pkg::*;
#(
    parameter int unsigned DAYS_PER_MONTH = 30,
    parameter int unsigned MONTHS         = 12,
    parameter int unsigned DAY_W          = 5,
    parameter int unsigned MON_W          = 4
) (
    input  logic [DAY_W-1:0] day,
    input  logic [MON_W-1:0] mon,
    input  logic             dir,
    output logic [DAY_W-1:0] day_n,
    output logic [MON_W-1:0] mon_n,
    output logic             wrap_n
);

    logic [MON_W-1:0] mon_prev;
    logic [MON_W-1:0] mon_next;
    logic [31:0]      len_cur;
    logic [31:0]      len_prev;

    always_comb begin
        mon_prev = (mon == MON_W'(1)) ? MON_W'(MONTHS) : mon - MON_W'(1);
        mon_next = (mon == MON_W'(MONTHS)) ? MON_W'(1) : mon + MON_W'(1);
    end

`ifdef REAL_MONTH_LEN_EN
    assign len_cur  = month_len(32'(mon));
    assign len_prev = month_len(32'(mon_prev));
`else
    assign len_cur  = DAYS_PER_MONTH;
    assign len_prev = DAYS_PER_MONTH;
`endif

    always_comb begin
        day_n  = day;
        mon_n  = mon;
        wrap_n = 1'b0;
        if (dir == DIR_FWD) begin
            if (32'(day) < len_cur) begin
                day_n = day + DAY_W'(1);
            end else begin
                day_n  = DAY_W'(1);
                mon_n  = mon_next;
                wrap_n = (mon == MON_W'(MONTHS));
            end
        end else begin
            if (day > DAY_W'(1)) begin
                day_n = day - DAY_W'(1);
            end else begin
                day_n  = DAY_W'(len_prev);
                mon_n  = mon_prev;
                wrap_n = (mon == MON_W'(1));
            end
        end
    end

endmodule

// File: rtl/day_offset_calc.sv
// Sequential calendar engine: returns the date N days before/after (day, month), one day per clock.
// REAL_MONTH_LEN_EN enables real month lengths (requires MONTHS == 12 and DAY_W >= 5).
module day_offset_calc
    import cal_pkg::*;
#(
    parameter int unsigned DAYS_PER_MONTH = 30,
    parameter int unsigned MONTHS         = 12,
    parameter int unsigned DAY_W          = 5,
    parameter int unsigned MON_W          = 4,
    parameter int unsigned OFF_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DAY_W-1:0] req_day,
    input  logic [MON_W-1:0] req_mon,
    input  logic [OFF_W-1:0] req_off,
    input  logic             req_dir,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAY_W-1:0] rsp_day,
    output logic [MON_W-1:0] rsp_mon,
    output logic             rsp_wrap,
    output logic             rsp_err
);

`ifdef REAL_MONTH_LEN_EN
    if (MONTHS != 12 || DAY_W < 5) begin : g_bad_cfg
        $error("day_offset_calc: real month lengths need MONTHS == 12 and DAY_W >= 5");
    end
`endif

    state_t           state;
    logic [OFF_W-1:0] cnt;
    logic [DAY_W-1:0] cur_day;
    logic [MON_W-1:0] cur_mon;
    logic             cur_dir;
    logic             wrap;

    logic [DAY_W-1:0] day_n;
    logic [MON_W-1:0] mon_n;
    logic             wrap_n;
    logic [31:0]      req_len;
    logic             req_bad;

`ifdef REAL_MONTH_LEN_EN
    assign req_len = month_len(32'(req_mon));
`else
    assign req_len = DAYS_PER_MONTH;
`endif

    assign req_bad = (req_day == '0) || (req_mon == '0) ||
                     (32'(req_mon) > MONTHS) || (32'(req_day) > req_len);

    day_step #(
        .DAYS_PER_MONTH (DAYS_PER_MONTH),
        .MONTHS         (MONTHS),
        .DAY_W          (DAY_W),
        .MON_W          (MON_W)
    ) u_step (
        .day    (cur_day),
        .mon    (cur_mon),
        .dir    (cur_dir),
        .day_n  (day_n),
        .mon_n  (mon_n),
        .wrap_n (wrap_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_day   <= '0;
            rsp_mon   <= '0;
            rsp_wrap  <= 1'b0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            cur_day   <= '0;
            cur_mon   <= '0;
            cur_dir   <= DIR_BACK;
            wrap      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cur_day   <= req_day;
                        cur_mon   <= req_mon;
                        cur_dir   <= req_dir;
                        cnt       <= req_off;
                        wrap      <= 1'b0;
                        req_ready <= 1'b0;
                        // Errors and zero offsets answer immediately with the inputs echoed.
                        if (req_bad || req_off == '0) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_day   <= req_day;
                            rsp_mon   <= req_mon;
                            rsp_wrap  <= 1'b0;
                            rsp_err   <= req_bad;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                STEP: begin
                    cur_day <= day_n;
                    cur_mon <= mon_n;
                    wrap    <= wrap | wrap_n;
                    cnt     <= cnt - OFF_W'(1);
                    if (cnt == OFF_W'(1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_day   <= day_n;
                        rsp_mon   <= mon_n;
                        rsp_wrap  <= wrap | wrap_n;
                        rsp_err   <= 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
